// File: rtl/alu_result_drain.sv
// alu_result_drain: buffers 64-bit ALU results in a small FIFO and drains
// each one onto the 32-bit bus as LO and/or HI words under valid/ready.
// Ports: clk, clr_n (async active-low), in_valid/in_ready/in_c/in_mode (push
// side), bus_valid/bus_ready/bus_out/bus_sel/bus_last (bus side), count.
// Optional macro ALU_RESULT_FLAGS_EN adds per-entry zero/neg flags on
// bus_zero/bus_neg.
module alu_result_drain #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      clr_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*DATA_W-1:0]       in_c,
    input  logic [1:0]                in_mode,
    output logic                      bus_valid,
    input  logic                      bus_ready,
    output logic [DATA_W-1:0]         bus_out,
    output logic                      bus_sel,
    output logic                      bus_last,
`ifdef ALU_RESULT_FLAGS_EN
    output logic                      bus_zero,
    output logic                      bus_neg,
`endif
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] M_LO   = 2'b00;
    localparam logic [1:0] M_HI   = 2'b01;
    localparam logic [1:0] M_LOHI = 2'b10;
    localparam logic [1:0] M_DROP = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [2*DATA_W-1:0] mem_c_q    [DEPTH];
    logic [1:0]          mem_mode_q [DEPTH];

    logic                push;
    logic                pop;
    logic [PW-1:0]       rd_nxt;
    logic [1:0]          head_mode;
    logic [2*DATA_W-1:0] head_c;
    logic                nxt_avail;
    logic [1:0]          nxt_mode;
    state_e              nxt_first;

    // First bus state of an entry; discard entries are handled from IDLE.
    function automatic state_e first_state(input logic [1:0] m);
        state_e s;
        unique case (m)
            M_HI:    s = S_HI;
            M_DROP:  s = S_IDLE;
            default: s = S_LO;
        endcase
        return s;
    endfunction

    assign in_ready  = (count_q < CW'(DEPTH));
    assign push      = in_valid & in_ready;
    assign rd_nxt    = rd_ptr_q + PW'(1);
    assign head_mode = mem_mode_q[rd_ptr_q];
    assign head_c    = mem_c_q[rd_ptr_q];
    assign count     = count_q;

    // Entry that follows the head: already stored, or being pushed now
    // (forwarded so a pop never leaves a bubble when work is arriving).
    always_comb begin
        nxt_avail = 1'b0;
        nxt_mode  = M_DROP;
        if (count_q > CW'(1)) begin
            nxt_avail = 1'b1;
            nxt_mode  = mem_mode_q[rd_nxt];
        end else if (push) begin
            nxt_avail = 1'b1;
            nxt_mode  = in_mode;
        end
        nxt_first = nxt_avail ? first_state(nxt_mode) : S_IDLE;
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        bus_valid = 1'b0;
        bus_out   = '0;
        bus_sel   = 1'b0;
        bus_last  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    unique case (head_mode)
                        M_DROP: begin
                            pop     = 1'b1;
                            state_d = nxt_first;
                        end
                        M_HI:    state_d = S_HI;
                        default: state_d = S_LO;
                    endcase
                end
            end
            S_LO: begin
                bus_valid = 1'b1;
                bus_out   = head_c[DATA_W-1:0];
                bus_last  = (head_mode == M_LO);
                if (bus_ready) begin
                    if (head_mode == M_LOHI) begin
                        state_d = S_HI;
                    end else begin
                        pop     = 1'b1;
                        state_d = nxt_first;
                    end
                end
            end
            S_HI: begin
                bus_valid = 1'b1;
                bus_sel   = 1'b1;
                bus_out   = head_c[2*DATA_W-1:DATA_W];
                bus_last  = 1'b1;
                if (bus_ready) begin
                    pop     = 1'b1;
                    state_d = nxt_first;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_nxt : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_c_q[wr_ptr_q]    <= in_c;
            mem_mode_q[wr_ptr_q] <= in_mode;
        end
    end

`ifdef ALU_RESULT_FLAGS_EN
    logic mem_zero_q [DEPTH];
    logic mem_neg_q  [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_zero_q[wr_ptr_q] <= (in_c == '0);
            mem_neg_q[wr_ptr_q]  <= in_c[2*DATA_W-1];
        end
    end

    assign bus_zero = bus_valid & mem_zero_q[rd_ptr_q];
    assign bus_neg  = bus_valid & mem_neg_q[rd_ptr_q];
`endif

endmodule
